// File: rtl/lfsr_5bit.sv
// rtl/lfsr_5bit.sv - free-running 5-bit maximal-length Fibonacci LFSR (x^5 + x^3 + 1)
module lfsr_5bit #(
  parameter logic [4:0] SEED = 5'b00001
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  output logic [4:0] Q
);

  // Next-state net; the name is kept stable so benches can probe it hierarchically.
  logic [4:0] Q_next;
  logic       fb;

  // Next state: shift left with tap feedback; all-zero lock-up recovers to SEED.
  always_comb begin
    fb     = Q[4] ^ Q[2];
    Q_next = {Q[3:0], fb};
    if (Q == 5'b00000) begin
      Q_next = SEED;
    end
  end

  // State register: synchronous active-low reset loads SEED, otherwise advance.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      Q <= SEED;
    end else begin
      Q <= Q_next;
    end
  end

endmodule

// File: tb/tb_lfsr_5bit.sv
// tb/tb_lfsr_5bit.sv - scoreboard bench for lfsr_5bit (default seed and seed 10101)
module tb_lfsr_5bit;

  logic       sys_clk;
  logic       sys_rst_n;
  logic [4:0] q1;
  logic [4:0] q2;

  lfsr_5bit dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .Q        (q1)
  );

  lfsr_5bit #(.SEED(5'b10101)) dut2 (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .Q        (q2)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Hand-computed period of x^5+x^3+1 starting from 00001 (fb = Q[4]^Q[2], shift left).
  logic [4:0] seq [31];
  initial begin
    seq[0]  = 5'b00001; seq[1]  = 5'b00010; seq[2]  = 5'b00100; seq[3]  = 5'b01001;
    seq[4]  = 5'b10010; seq[5]  = 5'b00101; seq[6]  = 5'b01011; seq[7]  = 5'b10110;
    seq[8]  = 5'b01100; seq[9]  = 5'b11001; seq[10] = 5'b10011; seq[11] = 5'b00111;
    seq[12] = 5'b01111; seq[13] = 5'b11111; seq[14] = 5'b11110; seq[15] = 5'b11100;
    seq[16] = 5'b11000; seq[17] = 5'b10001; seq[18] = 5'b00011; seq[19] = 5'b00110;
    seq[20] = 5'b01101; seq[21] = 5'b11011; seq[22] = 5'b10111; seq[23] = 5'b01110;
    seq[24] = 5'b11101; seq[25] = 5'b11010; seq[26] = 5'b10101; seq[27] = 5'b01010;
    seq[28] = 5'b10100; seq[29] = 5'b01000; seq[30] = 5'b10000;
  end

  localparam int SEED1_IDX = 0;   // 00001
  localparam int SEED2_IDX = 26;  // 10101

  typedef struct {
    logic [4:0] q1;
    logic [4:0] n1;
    logic [4:0] q2;
    int         tag;
  } exp_t;

  exp_t exp_q [$];
  int   vectors   = 0;
  int   miscompares = 0;
  int   idx1 = 0;
  int   idx2 = 0;
  int   tag  = 0;

  task automatic check(input string name, input int t, input logic [4:0] got, input logic [4:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s item %0d: got %b want %b", name, t, got, want);
    end
  endtask

  task automatic push_expected();
    exp_t e;
    e.q1  = seq[idx1];
    e.n1  = seq[(idx1 + 1) % 31];
    e.q2  = seq[idx2];
    e.tag = tag;
    tag++;
    exp_q.push_back(e);
  endtask

  // One clock with the given reset level; expected state pushed after the edge.
  task automatic step(input logic rst_n_val);
    sys_rst_n = rst_n_val;
    @(posedge sys_clk);
    if (!rst_n_val) begin
      idx1 = SEED1_IDX;
      idx2 = SEED2_IDX;
    end else begin
      idx1 = (idx1 + 1) % 31;
      idx2 = (idx2 + 1) % 31;
    end
    push_expected();
    @(negedge sys_clk);
  endtask

  // Monitor: every falling edge, pop one expected entry and compare.
  always @(negedge sys_clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("q_seed1", e.tag, q1, e.q1);
      check("q_next_seed1", e.tag, dut.Q_next, e.n1);
      check("q_seed2", e.tag, q2, e.q2);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Reset held for two edges.
    step(1'b0);
    step(1'b0);

    // Two full periods after release.
    for (int i = 0; i < 62; i++) step(1'b1);

    // Advance to 10110 then pulse reset for one edge.
    for (int i = 0; i < 7; i++) step(1'b1);
    step(1'b0);
    step(1'b1);

    // Reset glitch between edges must not be seen.
    #2 sys_rst_n = 1'b0;
    #2 sys_rst_n = 1'b1;
    step(1'b1);
    step(1'b1);

    // Lock-up recovery: force the state to zero, release, next edge gives SEED.
    #2 force dut.Q = 5'b00000;
    #1 check("forced_q", tag, q1, 5'b00000);
    check("forced_q_next", tag, dut.Q_next, 5'b00001);
    release dut.Q;
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    idx1 = SEED1_IDX;
    idx2 = (idx2 + 1) % 31;
    push_expected();
    @(negedge sys_clk);
    for (int i = 0; i < 5; i++) step(1'b1);

    repeat (2) @(negedge sys_clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
